// File: rtl/seq_detector_param.sv
// Serial bit-sequence detector with a pattern, length and overlap mode
// that are loaded at run time. Produces a registered match pulse and a
// saturating match counter.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | no valid configuration loaded, armed=0
// S_HUNT  | configured, fewer than cfg_len bits collected (fill < cfg_len)
// S_TRACK | configured, full pattern window available (fill >= cfg_len)
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap_en,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed
);

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_TRACK} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t             state, state_nxt;
  logic [MAX_LEN-1:0] hist, hist_sh, cfg_pat, len_mask;
  logic [LEN_W-1:0]   cfg_len, fill, fill_inc, len_clamp;
  logic [LEN_W:0]     fill_p1;
  logic               cfg_ovl, hit;

  // Lengths beyond the history depth are treated as the full depth.
  assign len_clamp = (pat_len > MAX_LEN_L) ? MAX_LEN_L : pat_len;
  assign hist_sh   = {hist[MAX_LEN-2:0], x};
  assign fill_inc  = (fill == MAX_LEN_L) ? fill : fill + LEN_W'(1);
  assign fill_p1   = {1'b0, fill} + (LEN_W+1)'(1);
  assign armed     = (state != S_IDLE);

  // Only the low cfg_len bits of the pattern take part in the compare.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(cfg_len));
    end
  end

  // Match is judged on the history as it will look after this bit shifts in.
  assign hit = armed && (fill_p1 >= {1'b0, cfg_len}) &&
               (((hist_sh ^ cfg_pat) & len_mask) == '0);

  // Configuration latch, history shift register, fill tracking and match pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_pat <= '0;
      cfg_len <= '0;
      cfg_ovl <= 1'b0;
      hist    <= '0;
      fill    <= '0;
      match   <= 1'b0;
    end else if (cfg_load) begin
      cfg_pat <= pattern;
      cfg_len <= len_clamp;
      cfg_ovl <= overlap_en;
      hist    <= '0;
      fill    <= '0;
      match   <= 1'b0;
    end else if (in_valid) begin
      hist  <= hist_sh;
      fill  <= (hit && !cfg_ovl) ? '0 : fill_inc;
      match <= hit;
    end else begin
      match <= 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; follows the same fill bookkeeping as the datapath.
  always_comb begin
    state_nxt = state;
    if (cfg_load) begin
      state_nxt = (len_clamp == '0) ? S_IDLE : S_HUNT;
    end else if (in_valid && (state != S_IDLE)) begin
      if (hit && !cfg_ovl) begin
        state_nxt = S_HUNT;
      end else if (fill_inc >= cfg_len) begin
        state_nxt = S_TRACK;
      end
    end
  end

  // Saturating counter of registered match pulses; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (match && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param with a 2-bit counter so that
// saturation is reachable in a few cycles.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 2;

  logic               clk;
  logic               rst_n;
  logic               x;
  logic               in_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap_en;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               armed;

  int checks = 0;
  int errors = 0;

  seq_detector_param #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .in_valid  (in_valid),
    .cfg_load  (cfg_load),
    .pattern   (pattern),
    .pat_len   (pat_len),
    .overlap_en(overlap_en),
    .cnt_clr   (cnt_clr),
    .match     (match),
    .match_cnt (match_cnt),
    .armed     (armed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus, then check match just after the edge.
  task automatic step(input logic v, input logic b, input logic clr, input logic exp_m,
                      input string tag);
    @(negedge clk);
    in_valid = v;
    x        = b;
    cnt_clr  = clr;
    cfg_load = 1'b0;
    @(posedge clk);
    #1;
    chk(tag, {31'd0, match}, {31'd0, exp_m});
  endtask

  // Load a configuration with a valid bit present that must be discarded.
  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                     input logic exp_armed, input string tag);
    @(negedge clk);
    cfg_load   = 1'b1;
    pattern    = pat;
    pat_len    = len;
    overlap_en = ovl;
    in_valid   = 1'b1;
    x          = 1'b1;
    cnt_clr    = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_match"}, {31'd0, match}, 32'd0);
    chk({tag, "_armed"}, {31'd0, armed}, {31'd0, exp_armed});
  endtask

  // Send n bits, first bit is bits[n-1]; exp[n-1-k] is the match after bit k.
  task automatic send(input logic [7:0] bits, input int n, input logic [7:0] exp,
                      input string tag);
    for (int k = 0; k < n; k++) begin
      step(1'b1, bits[n-1-k], 1'b0, exp[n-1-k], $sformatf("%s_b%0d", tag, k + 1));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    x          = 1'b0;
    in_valid   = 1'b0;
    cfg_load   = 1'b0;
    pattern    = '0;
    pat_len    = '0;
    overlap_en = 1'b0;
    cnt_clr    = 1'b0;
    #1;
    chk("rst_match", {31'd0, match}, 32'd0);
    chk("rst_cnt",   {30'd0, match_cnt}, 32'd0);
    chk("rst_armed", {31'd0, armed}, 32'd0);
    #12 rst_n = 1'b1;

    // 1: non-overlap 1101 over 1101101
    cfg(8'b0000_1101, 4'd4, 1'b0, 1'b1, "t1_cfg");
    step(1'b0, 1'b0, 1'b1, 1'b0, "t1_clr");
    send(8'b0110_1101, 7, 8'b0000_1000, "t1");
    step(1'b0, 1'b0, 1'b0, 1'b0, "t1_idle");
    chk("t1_cnt", {30'd0, match_cnt}, 32'd1);

    // 2: overlap, same stream
    cfg(8'b0000_1101, 4'd4, 1'b1, 1'b1, "t2_cfg");
    step(1'b0, 1'b0, 1'b1, 1'b0, "t2_clr");
    send(8'b0110_1101, 7, 8'b0000_1001, "t2");
    step(1'b0, 1'b0, 1'b0, 1'b0, "t2_idle");
    chk("t2_cnt", {30'd0, match_cnt}, 32'd2);

    // 3: gaps in in_valid do not break the sequence
    cfg(8'b0000_1101, 4'd4, 1'b1, 1'b1, "t3_cfg");
    send(8'b0000_0011, 2, 8'b0000_0000, "t3a");
    step(1'b0, 1'b1, 1'b0, 1'b0, "t3_gap1");
    step(1'b0, 1'b0, 1'b0, 1'b0, "t3_gap2");
    step(1'b0, 1'b1, 1'b0, 1'b0, "t3_gap3");
    send(8'b0000_0001, 2, 8'b0000_0001, "t3b");
    step(1'b0, 1'b0, 1'b0, 1'b0, "t3_idle");

    // 4: length clamp to 8, then length 0 disarms
    cfg(8'hA5, 4'd12, 1'b0, 1'b1, "t4_cfg");
    send(8'hA5, 8, 8'h01, "t4a");
    step(1'b0, 1'b0, 1'b0, 1'b0, "t4_idle");
    cfg(8'hA5, 4'd0, 1'b0, 1'b0, "t4_cfg0");
    send(8'hA5, 8, 8'h00, "t4b");

    // 5: length 1, counter saturation and clear-vs-pulse priority
    cfg(8'h01, 4'd1, 1'b0, 1'b1, "t5_cfg");
    step(1'b0, 1'b0, 1'b1, 1'b0, "t5_clr");
    send(8'b0001_1111, 5, 8'b0001_1111, "t5a");
    chk("t5_cnt_run", {30'd0, match_cnt}, 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, "t5_idle");
    chk("t5_cnt_sat", {30'd0, match_cnt}, 32'd3);
    send(8'b0000_0101, 3, 8'b0000_0101, "t5b");
    step(1'b0, 1'b0, 1'b1, 1'b0, "t5_clrpulse");
    chk("t5_cnt_clr", {30'd0, match_cnt}, 32'd0);
    send(8'b0000_0011, 2, 8'b0000_0011, "t5c");
    step(1'b0, 1'b0, 1'b0, 1'b0, "t5_idle2");
    chk("t5_cnt_2", {30'd0, match_cnt}, 32'd2);

    // 6: reset in the middle of a partial sequence
    cfg(8'b0000_1101, 4'd4, 1'b0, 1'b1, "t6_cfg");
    send(8'b0000_0110, 3, 8'b0000_0000, "t6a");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("t6_rst_armed", {31'd0, armed}, 32'd0);
    chk("t6_rst_cnt",   {30'd0, match_cnt}, 32'd0);
    chk("t6_rst_match", {31'd0, match}, 32'd0);
    #3 rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, "t6_unarmed");
    chk("t6_unarmed_armed", {31'd0, armed}, 32'd0);
    cfg(8'b0000_1101, 4'd4, 1'b0, 1'b1, "t6_recfg");
    send(8'b0000_0001, 1, 8'b0000_0000, "t6b");
    send(8'b0000_1101, 4, 8'b0000_0001, "t6c");
    step(1'b0, 1'b0, 1'b0, 1'b0, "t6_idle");
    chk("t6_cnt", {30'd0, match_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-sequence detector; successor to the fixed 4-bit Mealy detectors in the FSM library.
- Pattern, pattern length and overlap mode are configured at run time.
- Provides a registered match pulse, a per-bit valid qualifier and a saturating match counter.
- Sits between a serial bit source (deserialiser or testbench stimulus) and control logic that counts or reacts to framing patterns.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits; legal range 2..32.
- LEN_W, 4: width of pat_len; must satisfy 2^LEN_W > MAX_LEN.
- CNT_W, 8: width of the match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- x  input  1  serial data bit.
- in_valid  input  1  x is sampled only on cycles where in_valid=1.
- cfg_load  input  1  one-cycle strobe that latches pattern, pat_len and overlap_en.
- pattern  input  MAX_LEN  target sequence; pattern[pat_len-1] is the first bit received, pattern[0] the last.
- pat_len  input  LEN_W  pattern length in bits.
- overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  input  1  synchronous clear of match_cnt.
- match  output  1  registered one-cycle pulse, one cycle after the final pattern bit is sampled.
- match_cnt  output  CNT_W  saturating count of matches.
- armed  output  1  1 when a valid configuration is loaded (1 <= effective length <= MAX_LEN).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: match=0, match_cnt=0, armed=0.
  - Internal state: hist=0, fill=0, cfg_pat=0, cfg_len=0, cfg_ovl=0.
- Configuration, on cfg_load=1:
  - cfg_pat <= pattern, cfg_ovl <= overlap_en.
  - cfg_len <= pat_len, clamped to MAX_LEN if pat_len > MAX_LEN.
  - hist <= 0 and fill <= 0.
  - armed <= (clamped length != 0).
  - Any in_valid bit in the same cycle is discarded; match <= 0 that cycle.
- Datapath, when in_valid=1 and cfg_load=0:
  - hist <= {hist[MAX_LEN-2:0], x}.
  - fill saturates at MAX_LEN.
  - Match condition, evaluated combinationally on the post-shift history: armed, (fill+1) >= cfg_len, and the low cfg_len bits of the new hist equal the low cfg_len bits of cfg_pat.
- Match response:
  - match <= 1 on the next edge, i.e. latency 1 cycle from the sampling edge of the last bit.
  - Overlap mode: fill continues incrementing and saturating, so suffix bits may begin a new match.
  - Non-overlap mode: fill <= 0 on a match, so the next match needs cfg_len fresh bits.
- When in_valid=0:
  - hist and fill hold; match <= 0.
  - Gaps in in_valid do not break a sequence.
- State machine:
  - IDLE (armed=0): no matching.
  - HUNT (fill < cfg_len).
  - TRACK (fill >= cfg_len).
  - Transitions: IDLE->HUNT on a valid cfg_load; HUNT->TRACK when fill reaches cfg_len; TRACK->HUNT on a non-overlap match or any cfg_load; any->IDLE on a cfg_load with length 0.
  - In TRACK in overlap mode, a match does not change state.
- Counter:
  - match_cnt increments on each cycle in which match is asserted (i.e. counts the registered pulse).
  - Saturates at 2^CNT_W-1 with no wrap.
  - If cnt_clr and a match pulse occur in the same cycle, clear wins and match_cnt=0.
- pat_len=1 is legal: every matching bit produces a pulse in both modes.
- Bits of pattern above cfg_len are ignored.
- Reset asserted mid-stream: all state is cleared immediately; no pulse is generated from partial history after reset release.

Test Plan:
1. Non-overlap: cfg pattern=8'b00001101, pat_len=4, overlap_en=0; stream 1,1,0,1,1,0,1 (in_valid=1) -> exactly one match pulse, one cycle after bit 4; match_cnt=1.
2. Overlap: same stream with overlap_en=1 -> pulses after bits 4 and 7; match_cnt=2.
3. Valid gaps: overlap config with pattern 1101; stream 1,1,[in_valid=0 for 3 cycles],0,1 -> single pulse after the final bit; no pulse during the gap.
4. Reconfigure/clamp: load pat_len=12 with MAX_LEN=8 and pattern=8'hA5 -> effective length 8; stream 10100101 -> one pulse. Then load pat_len=0 -> armed=0; stream 10100101 -> no pulse.
5. Counter: CNT_W=2, pat_len=1, pattern bit 1; drive 5 ones -> match_cnt saturates at 3. Assert cnt_clr coincident with a pulse -> match_cnt=0.
6. Reset mid-sequence: after 1,1,0 of pattern 1101, pulse rst_n low for half a cycle and reconfigure; send 1 -> no match; then send 1,1,0,1 -> one pulse.
